expr_eval: RTL and testbench
============================

EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16, setting the result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port in, input, 8, one ASCII character consumed per clk cycle.
REQ-005 The block SHALL have port result, output, WIDTH, the value of the expression received so far.
REQ-006 The block SHALL have port valid, output, 1, high when the stream so far is a complete legal expression.
REQ-007 The block SHALL have port err, output, 1, sticky high after a grammar violation.
REQ-008 The block SHALL have port ovf, output, 1, sticky arithmetic overflow flag.

Function
REQ-009 The block SHALL accept the grammar: single-digit operand ('0'-'9'), then zero or more (operator, single-digit operand) pairs; operators are '+' and '*'.
REQ-010 The block SHALL ignore in == 8'h00 entirely: no state, register or output change (idle filler).
REQ-011 The block SHALL use the FSM states EXP_DIG (reset state, expecting a digit), EXP_OP (last char was a digit), and ERR.
REQ-012 In the transitions of that FSM, a digit SHALL move EXP_DIG to EXP_OP, and an operator SHALL move EXP_OP to EXP_DIG.
REQ-013 In EXP_DIG or EXP_OP, any other non-zero character SHALL move the FSM to ERR, where it remains until clr.
REQ-014 The block SHALL give '*' precedence over '+' using registers sum and term, both WIDTH bits.
REQ-015 On a digit d, term SHALL become term*d if the pending operator is '*'; otherwise term SHALL become d.
REQ-016 On '+', sum SHALL become sum+term; on '*', sum SHALL be unchanged; in both cases the operator SHALL be latched as pending.
REQ-017 result SHALL be a register equal to sum+term, truncated to WIDTH bits, updated on the same edge that consumes a digit; latency is 1 cycle from in to result.
REQ-018 result SHALL hold its value on operator, 8'h00 and error characters.
REQ-019 valid SHALL be registered and high exactly when the FSM is in EXP_OP; it SHALL go low the cycle after an operator or an illegal character is consumed.
REQ-020 err SHALL be registered and high exactly when the FSM is in ERR; in ERR, sum, term and result SHALL freeze.
REQ-021 All arithmetic SHALL wrap modulo 2^WIDTH; ovf SHALL set when the untruncated value of any term product or sum addition exceeds 2^WIDTH-1.
REQ-022 Once set, ovf SHALL stay high until clr.
REQ-023 A character present in the same cycle as clr high SHALL be discarded.

Reset
REQ-024 On clr high at a clk edge: state SHALL become EXP_DIG, sum=0, term=0, pending op='+', result=0, valid=0, err=0, ovf=0.
REQ-025 clr mid-expression SHALL abandon the partial expression completely; the next digit SHALL start a fresh expression.

Configuration
REQ-026 With macro EXPR_EVAL_SUB_EN defined, '-' SHALL be a legal operator and arithmetic SHALL be two's complement signed.
REQ-027 With EXPR_EVAL_SUB_EN defined, a sign bit SHALL be added: on '+' or '-', sum SHALL become sum plus term, or sum minus term if the sign is negative, and the sign SHALL be set by the new operator.
REQ-028 With EXPR_EVAL_SUB_EN defined, result SHALL equal sum plus or minus term according to the sign, and ovf SHALL use signed range checks.
REQ-029 Without EXPR_EVAL_SUB_EN, '-' SHALL be illegal (moves the FSM to ERR) and arithmetic SHALL be unsigned.

Verification
REQ-030 Scenario: clr, idle 8'h00 x3, then "1+2*3" -> result=7, valid=1 one cycle after '3'; valid=0 after '+' and after '*'; err=0.
REQ-031 Scenario: "2*3*4+5" -> result=29, valid=1, ovf=0.
REQ-032 Scenario: "1+" then "a" then "3" -> err=1 from the cycle after 'a', valid=0, result stays 1 until clr.
REQ-033 Scenario: "1+2", clr pulse, "3" -> result=0 and valid=0 after clr, then result=3 and valid=1.
REQ-034 Scenario: "9*9*9*9*9*9" with WIDTH=16 -> result=7153 (531441 mod 65536), ovf=1, valid=1.
REQ-035 Scenario: EXPR_EVAL_SUB_EN defined, "1-2*3" -> result=16'hFFFB (-5), valid=1; without the macro the '-' gives err=1.

Source files
------------

// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit '+'/'*' expressions with '*' precedence.
// Define EXPR_EVAL_SUB_EN to add '-' and switch to two's complement signed arithmetic.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             err,
    output logic             ovf
);
    // state   | meaning
    // EXP_DIG | expecting a digit (reset, or after an operator)
    // EXP_OP  | last char was a digit; stream is a complete expression
    // ERR     | grammar violation seen; everything frozen until clr

`ifdef EXPR_EVAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        EXP_DIG = 2'd0,
        EXP_OP  = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             mul_q, mul_d;
    logic             neg_q, neg_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             is_digit, is_plus, is_mul, is_minus, is_addop;
    logic [3:0]       digit;
    logic [WIDTH+4:0] prod_x;
    logic [WIDTH-1:0] term_new;
    logic [WIDTH:0]   acc_x, res_x;
    logic             prod_ovf, acc_ovf, res_ovf;

    // Operands are widened with sign extension only in the signed build.
    function automatic logic [WIDTH:0] ext1(input logic [WIDTH-1:0] v);
        return {SUB_EN & v[WIDTH-1], v};
    endfunction

    function automatic logic [WIDTH+4:0] ext5(input logic [WIDTH-1:0] v);
        return {{5{SUB_EN & v[WIDTH-1]}}, v};
    endfunction

    function automatic logic add_ovf(input logic [WIDTH:0] x);
        return SUB_EN ? (x[WIDTH] ^ x[WIDTH-1]) : x[WIDTH];
    endfunction

    assign is_digit = (in >= "0") && (in <= "9");
    assign is_plus  = (in == "+");
    assign is_mul   = (in == "*");
    assign is_minus = (in == "-");
    assign is_addop = is_plus || (SUB_EN && is_minus);
    assign digit    = in[3:0];

    // Low bits of a product are identical for signed and unsigned when both operands are pre-extended.
    assign prod_x   = ext5(term_q) * {{(WIDTH+1){1'b0}}, digit};
    assign prod_ovf = SUB_EN ? !((&prod_x[WIDTH+4:WIDTH-1]) || !(|prod_x[WIDTH+4:WIDTH-1]))
                             : (|prod_x[WIDTH+4:WIDTH]);
    assign term_new = mul_q ? prod_x[WIDTH-1:0] : WIDTH'(digit);

    assign acc_x    = neg_q ? (ext1(sum_q) - ext1(term_q))   : (ext1(sum_q) + ext1(term_q));
    assign res_x    = neg_q ? (ext1(sum_q) - ext1(term_new)) : (ext1(sum_q) + ext1(term_new));
    assign acc_ovf  = add_ovf(acc_x);
    assign res_ovf  = add_ovf(res_x);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        term_d   = term_q;
        result_d = result_q;
        mul_d    = mul_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        if (in != 8'h00) begin
            case (state_q)
                EXP_DIG: begin
                    if (is_digit) begin
                        term_d   = term_new;
                        result_d = res_x[WIDTH-1:0];
                        ovf_d    = ovf_q | (mul_q & prod_ovf) | res_ovf;
                        state_d  = EXP_OP;
                    end else begin
                        state_d  = ERR;
                    end
                end
                EXP_OP: begin
                    if (is_addop) begin
                        sum_d   = acc_x[WIDTH-1:0];
                        ovf_d   = ovf_q | acc_ovf;
                        neg_d   = SUB_EN & is_minus;
                        mul_d   = 1'b0;
                        state_d = EXP_DIG;
                    end else if (is_mul) begin
                        mul_d   = 1'b1;
                        state_d = EXP_DIG;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        valid_d = (state_d == EXP_OP);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= EXP_DIG;
            sum_q    <= '0;
            term_q   <= '0;
            result_q <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            term_q   <= term_d;
            result_q <= result_d;
            mul_q    <= mul_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval (WIDTH=16): a reference evaluator fills a scoreboard per character,
// with fixed-value checks at the end of each directed scenario.
module tb_expr_eval;

`ifdef EXPR_EVAL_SUB_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in;
    logic [15:0] result;
    logic        valid, err, ovf;

    expr_eval #(.WIDTH(16)) dut (
        .clk(clk), .clr(clr), .in(in),
        .result(result), .valid(valid), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] result;
        logic        valid;
        logic        err;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference evaluator working on wide integers; 0=expect digit, 1=after digit, 2=error.
    int     m_state;
    longint m_sum, m_term, m_res;
    bit     m_mul, m_neg, m_ovf;

    function automatic longint wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        if (SUB) return longint'($signed(t));
        return longint'(t);
    endfunction

    function automatic bit oor(input longint v);
        if (SUB) return (v < -32768) || (v > 32767);
        return (v < 0) || (v > 65535);
    endfunction

    task automatic model(input logic [7:0] ch, input logic c);
        longint d, v;
        if (c) begin
            m_state = 0; m_sum = 0; m_term = 0; m_res = 0;
            m_mul = 0; m_neg = 0; m_ovf = 0;
            return;
        end
        if (ch == 8'h00) return;
        if (m_state == 0) begin
            if (ch >= "0" && ch <= "9") begin
                d = longint'(ch) - 48;
                if (m_mul) begin
                    v = m_term * d;
                    if (oor(v)) m_ovf = 1;
                    m_term = wrap16(v);
                end else begin
                    m_term = d;
                end
                v = m_neg ? (m_sum - m_term) : (m_sum + m_term);
                if (oor(v)) m_ovf = 1;
                m_res   = wrap16(v);
                m_state = 1;
            end else begin
                m_state = 2;
            end
        end else if (m_state == 1) begin
            if (ch == "+" || (SUB && ch == "-")) begin
                v = m_neg ? (m_sum - m_term) : (m_sum + m_term);
                if (oor(v)) m_ovf = 1;
                m_sum   = wrap16(v);
                m_neg   = (ch == "-");
                m_mul   = 0;
                m_state = 0;
            end else if (ch == "*") begin
                m_mul   = 1;
                m_state = 0;
            end else begin
                m_state = 2;
            end
        end
    endtask

    task automatic drive(input logic [7:0] ch, input logic c, input string tag);
        exp_t e;
        @(negedge clk);
        in  = ch;
        clr = c;
        model(ch, c);
        e.result = m_res[15:0];
        e.valid  = (m_state == 1);
        e.err    = (m_state == 2);
        e.ovf    = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (result === e.result) else begin
            failures++;
            $error("FAIL %s result: got %0h expected %0h", tag, result, e.result);
        end
        checks++;
        assert (valid === e.valid) else begin
            failures++;
            $error("FAIL %s valid: got %0b expected %0b", tag, valid, e.valid);
        end
        checks++;
        assert (err === e.err) else begin
            failures++;
            $error("FAIL %s err: got %0b expected %0b", tag, err, e.err);
        end
        checks++;
        assert (ovf === e.ovf) else begin
            failures++;
            $error("FAIL %s ovf: got %0b expected %0b", tag, ovf, e.ovf);
        end
    endtask

    task automatic send(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) drive(s[i], 1'b0, tag);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        in  = 8'h00;
        clr = 1'b1;
        drive(8'h00, 1'b1, "reset");
        drive(8'h00, 1'b1, "reset");
        chk("reset result", result, 16'd0);

        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, "idle");
        send("1+2*3", "prec");
        chk("prec result", result, 16'd7);
        chk("prec valid", 16'(valid), 16'd1);
        chk("prec err", 16'(err), 16'd0);
        drive(8'h00, 1'b0, "prec idle");
        chk("prec hold", result, 16'd7);

        drive(8'h00, 1'b1, "clr");
        send("2*3*4+5", "chain");
        chk("chain result", result, 16'd29);
        chk("chain valid", 16'(valid), 16'd1);
        chk("chain ovf", 16'(ovf), 16'd0);

        drive(8'h00, 1'b1, "clr");
        send("1+a3", "illegal");
        drive(8'h00, 1'b0, "illegal idle");
        chk("illegal err", 16'(err), 16'd1);
        chk("illegal valid", 16'(valid), 16'd0);
        chk("illegal result", result, 16'd1);

        drive(8'h00, 1'b1, "clr");
        send("1+2", "abandon");
        drive("7", 1'b1, "abandon clr");
        chk("abandon clr result", result, 16'd0);
        chk("abandon clr valid", 16'(valid), 16'd0);
        send("3", "fresh");
        chk("fresh result", result, 16'd3);
        chk("fresh valid", 16'(valid), 16'd1);

        drive(8'h00, 1'b1, "clr");
        send("9*9*9*9*9*9", "ovf");
        chk("ovf result", result, 16'd7153);
        chk("ovf flag", 16'(ovf), 16'd1);
        chk("ovf valid", 16'(valid), 16'd1);
        send("+1", "ovf sticky");
        drive(8'h00, 1'b1, "clr");
        chk("ovf cleared", 16'(ovf), 16'd0);

        send("9*9*9*9*9+9*9*9*9*9", "sum ovf");
        drive(8'h00, 1'b1, "clr");
        send("+", "op first");
        drive(8'h00, 1'b1, "clr");
        send("45", "two digits");
        chk("two digits result", result, 16'd4);

        drive(8'h00, 1'b1, "clr");
        send("1-2*3", "minus");
`ifdef EXPR_EVAL_SUB_EN
        chk("minus result", result, 16'hFFFB);
        chk("minus valid", 16'(valid), 16'd1);
        send("+9", "minus add");
        chk("minus add result", result, 16'd4);
`else
        chk("minus err", 16'(err), 16'd1);
        chk("minus result", result, 16'd1);
`endif

        chk("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
